// File: rtl/otf_pipe_pkg.sv
// Shared constants and helpers for the on-the-fly elastic pipe chain.
// Holds default width/depth, the depth limit and the occupancy width function.
package otf_pipe_pkg;

    localparam int OTF_DEF_WIDTH = 64;
    localparam int OTF_DEF_DEPTH = 4;
    localparam int OTF_MAX_DEPTH = 16;

    // Bits needed to count 0..depth valid stages.
    function automatic int otf_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/on_the_fly_pipe_stage.sv
// One stage of the elastic chain: a data register plus its valid bit.
// Ports: clk, rst_n, i_en (stage moves), i_clr (drop valid),
//        i_valid/i_data (incoming word), o_valid/o_data (stage contents).
module on_the_fly_pipe_stage
    import otf_pipe_pkg::*;
#(
    parameter int P_WIDTH = OTF_DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_clr,
    input  logic               i_valid,
    input  logic [P_WIDTH-1:0] i_data,
    output logic               o_valid,
    output logic [P_WIDTH-1:0] o_data
);

    logic               r_valid;
    logic [P_WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            // Flush drops the word but keeps the stale data.
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            // Data only toggles when a real word enters.
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/on_the_fly_pipe_chain.sv
// Bubble-collapsing elastic register chain with flush and occupancy count.
// Ports: clk, rst_n, data_in/in_valid/in_ready (upstream),
//        data_out/out_valid/out_ready (downstream), flush, occupancy.
module on_the_fly_pipe_chain
    import otf_pipe_pkg::*;
#(
    parameter int P_WIDTH = OTF_DEF_WIDTH,
    parameter int P_DEPTH = OTF_DEF_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [P_WIDTH-1:0]            data_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [P_WIDTH-1:0]            data_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    input  logic                          flush,
    output logic [otf_cnt_w(P_DEPTH)-1:0] occupancy
);

    localparam int LP_CW = otf_cnt_w(P_DEPTH);

    if (P_DEPTH < 1 || P_DEPTH > OTF_MAX_DEPTH) begin : g_bad_depth
        $error("P_DEPTH out of range");
    end

    logic [P_DEPTH-1:0] w_move;
    logic [P_DEPTH-1:0] w_v;
    logic [P_DEPTH-1:0] w_vin;
    logic [P_WIDTH-1:0] w_d   [P_DEPTH];
    logic [P_WIDTH-1:0] w_din [P_DEPTH];
    logic [LP_CW-1:0]   w_occ_nxt;
    logic [LP_CW-1:0]   r_occ;

    // A stage may advance if it is empty or the stage ahead advances,
    // so gaps in the chain are squeezed out under backpressure.
    always_comb begin
        w_move = '0;
        w_move[P_DEPTH-1] = out_ready | ~w_v[P_DEPTH-1];
        for (int i = P_DEPTH - 2; i >= 0; i--) begin
            w_move[i] = ~w_v[i] | w_move[i+1];
        end
    end

    // Held low during reset so nothing is taken while the chain clears.
    assign in_ready = w_move[0] & ~flush & rst_n;

    for (genvar g = 0; g < P_DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_vin[g] = in_valid & in_ready;
            assign w_din[g] = data_in;
        end else begin : g_body
            assign w_vin[g] = w_v[g-1];
            assign w_din[g] = w_d[g-1];
        end

        on_the_fly_pipe_stage #(
            .P_WIDTH (P_WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (w_move[g]),
            .i_clr   (flush),
            .i_valid (w_vin[g]),
            .i_data  (w_din[g]),
            .o_valid (w_v[g]),
            .o_data  (w_d[g])
        );
    end

    // Occupancy tracks the valid bits as they will be after this edge.
    always_comb begin
        w_occ_nxt = '0;
        for (int i = 0; i < P_DEPTH; i++) begin
            if (!flush && (w_move[i] ? w_vin[i] : w_v[i])) begin
                w_occ_nxt = w_occ_nxt + LP_CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ <= '0;
        end else begin
            r_occ <= w_occ_nxt;
        end
    end

    assign occupancy = r_occ;
    assign data_out  = w_d[P_DEPTH-1];
    assign out_valid = w_v[P_DEPTH-1] & ~flush;

endmodule
